// File: rtl/imem_dmem_port_arbiter.sv
// Arbitrates the single-port unified memory between fetch (IF) and load/store (DM).
// DM wins in IDLE; on completion the other requester is granted back-to-back so neither starves.
module imem_dmem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  input  logic [3:0]    dm_be,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [DW-1:0] mem_rdata,
  output logic [31:0]   if_stall_cycles
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;   // 1 = DM owns the port
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   if_stall_q;
  logic          done, grant, grant_dm;

  // A store completes in its ACCESS cycle; a read completes when the countdown hits zero.
  assign done = ((state_q == ACCESS) && we_q) || ((state_q == WAIT) && (cnt_q == '0));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    grant    = 1'b0;
    grant_dm = 1'b0;

    case (state_q)
      IDLE: begin
        if (dm_req) begin
          grant    = 1'b1;
          grant_dm = 1'b1;
        end else if (if_req) begin
          grant    = 1'b1;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          state_d = WAIT;
          cnt_d   = CW'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase

    // The completing requester's req is still high this cycle, so only the other side may be granted.
    if (done) begin
      state_d = IDLE;
      if (owner_q && if_req) begin
        grant    = 1'b1;
      end else if (!owner_q && dm_req) begin
        grant    = 1'b1;
        grant_dm = 1'b1;
      end
    end

    if (grant) begin
      state_d = ACCESS;
      owner_d = grant_dm;
      if (grant_dm) begin
        we_d    = dm_we;
        addr_d  = dm_addr;
        wdata_d = dm_wdata;
        be_d    = dm_we ? dm_be : 4'b0000;
      end else begin
        we_d    = 1'b0;
        addr_d  = if_addr;
        wdata_d = '0;
        be_d    = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_stall_q <= '0;
    end else if (if_req && !if_ready && (if_stall_q != 32'hFFFF_FFFF)) begin
      if_stall_q <= if_stall_q + 32'd1;
    end
  end

  assign mem_en          = (state_q == ACCESS);
  assign mem_we          = mem_en & we_q;
  assign mem_addr        = mem_en ? addr_q  : '0;
  assign mem_wdata       = mem_en ? wdata_q : '0;
  assign mem_be          = mem_en ? be_q    : 4'b0000;
  assign if_ready        = done & ~owner_q;
  assign dm_ready        = done & owner_q;
  assign if_rdata        = if_ready ? mem_rdata : '0;
  assign dm_rdata        = (dm_ready && !we_q) ? mem_rdata : '0;
  assign if_stall_cycles = if_stall_q;

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Directed bench: cycle table on a MEM_LAT=1 instance plus hand sequences for latency-3, reset and saturation.
module tb_imem_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_be = '0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, stall1;
  logic        if_ready1, dm_ready1, mem_en1, mem_we1;
  logic [3:0]  mem_be1;
  logic [31:0] if_rdata3, dm_rdata3, mem_addr3, mem_wdata3, stall3;
  logic        if_ready3, dm_ready3, mem_en3, mem_we3;
  logic [3:0]  mem_be3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imem_dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata1), .dm_ready(dm_ready1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_be(mem_be1), .mem_rdata(mem_rdata), .if_stall_cycles(stall1)
  );

  imem_dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata3), .if_ready(if_ready3),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata3), .dm_ready(dm_ready3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_be(mem_be3), .mem_rdata(mem_rdata), .if_stall_cycles(stall3)
  );

  typedef struct {
    logic        ifr;
    logic [31:0] ia;
    logic        dmr;
    logic        we;
    logic [31:0] da;
    logic [31:0] dw;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_ifr;
    logic [31:0] e_ifd;
    logic        e_dmr;
    logic [31:0] e_dmd;
    logic [31:0] e_stall;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_be = '0; mem_rdata = '0;
    repeat (n) next_cyc();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " dut1 outputs"}, 32'(|{mem_en1, mem_we1, mem_addr1, mem_wdata1, mem_be1,
        if_ready1, if_rdata1, dm_ready1, dm_rdata1, stall1}), 32'd0);
    chk({nm, " dut3 outputs"}, 32'(|{mem_en3, mem_we3, mem_addr3, mem_wdata3, mem_be3,
        if_ready3, if_rdata3, dm_ready3, dm_rdata3, stall3}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        ifr  ia      dmr  we  da      dw            be    rd            | en  we  addr    wdata         be    ifr ifd           dmr dmd           stall
    tbl[0]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        4'h0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        32'd0};
    tbl[1]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        4'h0, 32'hBAD00001, 1, 0, 32'h40,  32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        32'd1};
    tbl[2]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        4'h0, 32'h20080005, 0, 0, 32'h0,   32'h0,        4'h0, 1, 32'h20080005, 0, 32'h0,        32'd2};
    tbl[3]  = '{0, 32'h0,  0, 0, 32'h0,   32'h0,        4'h0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        32'd2};
    tbl[4]  = '{0, 32'h0,  1, 1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        32'd2};
    tbl[5]  = '{0, 32'h0,  1, 1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0,        1, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 32'h0,        1, 32'h0,        32'd2};
    tbl[6]  = '{0, 32'h0,  0, 0, 32'h0,   32'h0,        4'h0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        32'd2};
    tbl[7]  = '{1, 32'h80, 1, 0, 32'h200, 32'h0,        4'h0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        32'd2};
    tbl[8]  = '{1, 32'h80, 1, 0, 32'h200, 32'h0,        4'h0, 32'h0,        1, 0, 32'h200, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        32'd3};
    tbl[9]  = '{1, 32'h80, 1, 0, 32'h200, 32'h0,        4'h0, 32'h11111111, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        1, 32'h11111111, 32'd4};
    tbl[10] = '{1, 32'h80, 1, 0, 32'h200, 32'h0,        4'h0, 32'hBAD0000A, 1, 0, 32'h80,  32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        32'd5};
    tbl[11] = '{1, 32'h80, 1, 0, 32'h200, 32'h0,        4'h0, 32'h22222222, 0, 0, 32'h0,   32'h0,        4'h0, 1, 32'h22222222, 0, 32'h0,        32'd6};
    tbl[12] = '{1, 32'h80, 1, 0, 32'h200, 32'h0,        4'h0, 32'h0,        1, 0, 32'h200, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        32'd6};
    tbl[13] = '{1, 32'h80, 1, 0, 32'h200, 32'h0,        4'h0, 32'h33333333, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        1, 32'h33333333, 32'd7};
    tbl[14] = '{1, 32'h80, 1, 0, 32'h200, 32'h0,        4'h0, 32'h0,        1, 0, 32'h80,  32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        32'd8};
    tbl[15] = '{1, 32'h80, 0, 0, 32'h0,   32'h0,        4'h0, 32'h44444444, 0, 0, 32'h0,   32'h0,        4'h0, 1, 32'h44444444, 0, 32'h0,        32'd9};
    tbl[16] = '{0, 32'h0,  0, 0, 32'h0,   32'h0,        4'h0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0,        32'd9};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    next_cyc();

    // Fetch, store and contention as one continuous cycle table on the MEM_LAT=1 instance
    for (int i = 0; i < 17; i++) begin
      if_req = tbl[i].ifr; if_addr = tbl[i].ia; dm_req = tbl[i].dmr; dm_we = tbl[i].we;
      dm_addr = tbl[i].da; dm_wdata = tbl[i].dw; dm_be = tbl[i].be; mem_rdata = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("row%0d mem_en", i),    32'(mem_en1),    32'(tbl[i].e_en));
      chk($sformatf("row%0d mem_we", i),    32'(mem_we1),    32'(tbl[i].e_we));
      chk($sformatf("row%0d mem_addr", i),  mem_addr1,       tbl[i].e_addr);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata1,      tbl[i].e_wdata);
      chk($sformatf("row%0d mem_be", i),    32'(mem_be1),    32'(tbl[i].e_be));
      chk($sformatf("row%0d if_ready", i),  32'(if_ready1),  32'(tbl[i].e_ifr));
      chk($sformatf("row%0d if_rdata", i),  if_rdata1,       tbl[i].e_ifd);
      chk($sformatf("row%0d dm_ready", i),  32'(dm_ready1),  32'(tbl[i].e_dmr));
      chk($sformatf("row%0d dm_rdata", i),  dm_rdata1,       tbl[i].e_dmd);
      chk($sformatf("row%0d stall", i),     stall1,          tbl[i].e_stall);
      next_cyc();
    end
    idle(8);

    // MEM_LAT=3 load: mem_en in cycle 1, ready in cycle 4
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; mem_rdata = 32'hBAD00003;
    @(negedge clk); chk("lat3 c0 mem_en", 32'(mem_en3), 32'd0);
    next_cyc();
    @(negedge clk); chk("lat3 c1 mem_en", 32'(mem_en3), 32'd1);
    chk("lat3 c1 mem_addr", mem_addr3, 32'h200);
    next_cyc();
    @(negedge clk); chk("lat3 c2 dm_ready", 32'(dm_ready3), 32'd0);
    chk("lat3 c2 dm_rdata", dm_rdata3, 32'h0);
    next_cyc();
    @(negedge clk); chk("lat3 c3 dm_ready", 32'(dm_ready3), 32'd0);
    next_cyc();
    mem_rdata = 32'h5555AAAA;
    @(negedge clk); chk("lat3 c4 dm_ready", 32'(dm_ready3), 32'd1);
    chk("lat3 c4 dm_rdata", dm_rdata3, 32'h5555AAAA);
    idle(8);

    // Reset while the latency-3 instance is in WAIT
    if_req = 1'b1; if_addr = 32'h300; mem_rdata = 32'h77777777;
    next_cyc();
    next_cyc();
    #2;
    rst_n = 1'b0; if_req = 1'b0;
    #1;
    chk_zero("async reset");
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("post-reset c%0d if_ready3", k), 32'(if_ready3), 32'd0);
      chk($sformatf("post-reset c%0d dm_ready3", k), 32'(dm_ready3), 32'd0);
    end
    next_cyc();
    if_req = 1'b1; if_addr = 32'h400; mem_rdata = 32'h0;
    @(negedge clk); chk("post-reset fetch c0 if_ready", 32'(if_ready1), 32'd0);
    next_cyc();
    @(negedge clk); chk("post-reset fetch c1 mem_en", 32'(mem_en1), 32'd1);
    chk("post-reset fetch c1 mem_addr", mem_addr1, 32'h400);
    next_cyc();
    mem_rdata = 32'h99990000;
    @(negedge clk); chk("post-reset fetch c2 if_ready", 32'(if_ready1), 32'd1);
    chk("post-reset fetch c2 if_rdata", if_rdata1, 32'h99990000);
    chk("post-reset fetch c2 stall", stall1, 32'd2);
    idle(8);

    // Saturation of the fetch stall counter under DM streaming
    if_req = 1'b1; if_addr = 32'h500; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
    @(negedge clk);
    force dut1.if_stall_q = 32'hFFFF_FFFE;
    #1;
    release dut1.if_stall_q;
    for (int k = 0; k < 8; k++) begin
      next_cyc();
      @(negedge clk);
      chk($sformatf("saturate c%0d stall", k), stall1, 32'hFFFF_FFFF);
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
